// File: rtl/dp_mem_responder_if.sv
// Datapath/RAM signal bundle served by dp_mem_responder.
// The slave modport is the responder's view; master is the datapath-plus-RAM side.
interface dp_mem_responder_if;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic [31:0] imemload;
    logic        ihit;
    logic        dmemREN;
    logic        dmemWEN;
    logic [31:0] dmemaddr;
    logic [31:0] dmemstore;
    logic [31:0] dmemload;
    logic        dhit;
    logic        halt;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic        ramready;
    logic        timeout;

    modport slave (
        input  imemREN, imemaddr, dmemREN, dmemWEN, dmemaddr, dmemstore, halt, ramload, ramready,
        output imemload, ihit, dmemload, dhit, ramREN, ramWEN, ramaddr, ramstore, timeout
    );

    modport master (
        output imemREN, imemaddr, dmemREN, dmemWEN, dmemaddr, dmemstore, halt, ramload, ramready,
        input  imemload, ihit, dmemload, dhit, ramREN, ramWEN, ramaddr, ramstore, timeout
    );
endinterface

// File: rtl/dp_mem_responder.sv
// Serves datapath fetch/data requests over one RAM port (data first), with a sticky wait-state timeout.
// Define DP_RESP_IBUF_EN to add a one-entry fetch buffer that answers repeat fetches without the RAM.
module dp_mem_responder #(
    parameter int          MAX_WAIT = 16,
    parameter logic [31:0] ERR_WORD = 32'hBAD1BAD1
) (
    input logic               CLK,
    input logic               RST,
    dp_mem_responder_if.slave bus
);
    localparam int          CW        = $clog2(MAX_WAIT + 1);
    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {IDLE, RAM_WAIT, RESP, HALTED} state_t;
    typedef enum logic [1:0] {REQ_FETCH, REQ_READ, REQ_WRITE} req_kind_t;

    state_t        state, state_nxt;
    req_kind_t     req_kind;
    logic [31:0]   req_addr, req_store;
    logic [CW-1:0] wait_cnt;
    logic          halt_pend;
    logic [31:0]   imem_word, dmem_word;
    logic          timeout_q;
    logic          accept_d, accept_i, ibuf_hit, ram_done, ram_tmo;
    logic          ibuf_match;
    logic [31:0]   ibuf_word;
    logic [31:0]   done_word;

`ifdef DP_RESP_IBUF_EN
    logic        ibuf_valid;
    logic [31:0] ibuf_tag;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ibuf_valid <= 1'b0;
            ibuf_tag   <= '0;
            ibuf_word  <= '0;
        end else if (ram_done && req_kind == REQ_FETCH) begin
            ibuf_valid <= 1'b1;
            ibuf_tag   <= req_addr;
            ibuf_word  <= bus.ramload;
        end else if (accept_d && bus.dmemWEN && ((bus.dmemaddr & WORD_MASK) == ibuf_tag)) begin
            ibuf_valid <= 1'b0;
        end
    end

    assign ibuf_match = ibuf_valid && ((bus.imemaddr & WORD_MASK) == ibuf_tag);
`else
    assign ibuf_match = 1'b0;
    assign ibuf_word  = '0;
`endif

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_nxt = state;
        accept_d  = 1'b0;
        accept_i  = 1'b0;
        ibuf_hit  = 1'b0;
        ram_done  = 1'b0;
        ram_tmo   = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.halt) begin
                    state_nxt = HALTED;
                end else if (bus.dmemREN || bus.dmemWEN) begin
                    accept_d  = 1'b1;
                    state_nxt = RAM_WAIT;
                end else if (bus.imemREN && ibuf_match) begin
                    ibuf_hit  = 1'b1;
                    state_nxt = RESP;
                end else if (bus.imemREN) begin
                    accept_i  = 1'b1;
                    state_nxt = RAM_WAIT;
                end
            end
            RAM_WAIT: begin
                if (bus.ramready) begin
                    ram_done  = 1'b1;
                    state_nxt = RESP;
                end else if (wait_cnt == CW'(MAX_WAIT - 1)) begin
                    ram_tmo   = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = (bus.halt || halt_pend) ? HALTED : IDLE;
            HALTED:  state_nxt = HALTED;
            default: state_nxt = IDLE;
        endcase
    end

    assign done_word = ram_tmo ? ERR_WORD : bus.ramload;

    // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            req_kind  <= REQ_FETCH;
            req_addr  <= '0;
            req_store <= '0;
            wait_cnt  <= '0;
            halt_pend <= 1'b0;
            imem_word <= '0;
            dmem_word <= '0;
            timeout_q <= 1'b0;
        end else begin
            state <= state_nxt;

            if (accept_d) begin
                req_kind  <= bus.dmemWEN ? REQ_WRITE : REQ_READ;
                req_addr  <= bus.dmemaddr & WORD_MASK;
                req_store <= bus.dmemstore;
            end else if (accept_i || ibuf_hit) begin
                req_kind <= REQ_FETCH;
                req_addr <= bus.imemaddr & WORD_MASK;
            end

            if (accept_d || accept_i) begin
                wait_cnt <= '0;
            end else if (state == RAM_WAIT && wait_cnt != CW'(MAX_WAIT)) begin
                wait_cnt <= wait_cnt + 1'b1;
            end

            // A halt seen mid-access is remembered so the access can finish before halting.
            if (state == IDLE) begin
                halt_pend <= 1'b0;
            end else if (bus.halt) begin
                halt_pend <= 1'b1;
            end

            if (ram_done || ram_tmo) begin
                if (req_kind == REQ_FETCH) begin
                    imem_word <= done_word;
                end else if (req_kind == REQ_READ) begin
                    dmem_word <= done_word;
                end
            end else if (ibuf_hit) begin
                imem_word <= ibuf_word;
            end

            if (ram_tmo) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign bus.ramREN   = (state == RAM_WAIT) && (req_kind != REQ_WRITE);
    assign bus.ramWEN   = (state == RAM_WAIT) && (req_kind == REQ_WRITE);
    assign bus.ramaddr  = (state == RAM_WAIT) ? req_addr : '0;
    assign bus.ramstore = bus.ramWEN ? req_store : '0;
    assign bus.ihit     = (state == RESP) && (req_kind == REQ_FETCH);
    assign bus.dhit     = (state == RESP) && (req_kind != REQ_FETCH);
    assign bus.imemload = imem_word;
    assign bus.dmemload = dmem_word;
    assign bus.timeout  = timeout_q;
endmodule
